sysmgr_rst_ctrl: RTL and testbench

//  Reset and boot controller upstream of the PLL clock/reset generator. Runs on the raw board

---
 rtl/sysmgr_rst_ctrl.sv | 146 ++++++++++++++
 tb/tb_sysmgr_rst_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysmgr_rst_ctrl.sv
// rtl/sysmgr_rst_ctrl.sv - power-on/button reset sequencer feeding the PLL reset and warmboot request
// Button is synchronised and debounced; short press pulses pll_rst, long press latches a warmboot.
module sysmgr_rst_ctrl #(
  parameter int unsigned POR_CYCLES  = 16384,
  parameter int unsigned DEB_CYCLES  = 65536,
  parameter int unsigned RST_CYCLES  = 1024,
  parameter int unsigned LONG_CYCLES = 2**24,
  parameter logic [1:0]  BOOT_IMG    = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  output logic       pll_rst,
  output logic       long_ind,
  output logic       wb_boot,
  output logic [1:0] wb_sel
);

  localparam int unsigned MAX_A   = (POR_CYCLES > RST_CYCLES) ? POR_CYCLES : RST_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > LONG_CYCLES) ? MAX_A : LONG_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT);
  localparam int unsigned DW      = $clog2(DEB_CYCLES);

  localparam logic [CW-1:0] POR_T  = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] RST_T  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LONG_T = CW'(LONG_CYCLES - 1);
  localparam logic [DW-1:0] DEB_T  = DW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_POR,
    ST_IDLE,
    ST_PRESS,
    ST_SRST,
    ST_LONG,
    ST_BOOT
  } state_e;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          pll_rst_q, long_ind_q, wb_boot_q;
  logic          pressed;

  // Counter tracks how long the synchronised level has disagreed with the debounced one.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_T) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // The FSM reacts to the level the debouncer is committing this cycle.
  assign pressed = ~deb_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | ((state_q != ST_POR) & deb_d);
    case (state_q)
      ST_POR: begin
        if (cnt_q == POR_T) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pressed && armed_q) begin
          state_d = ST_PRESS;
          cnt_d   = '0;
        end
      end
      ST_PRESS: begin
        if (cnt_q == LONG_T) begin
          state_d = ST_LONG;
        end else if (!pressed) begin
          state_d = ST_SRST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SRST: begin
        if (cnt_q == RST_T) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (!pressed) begin
          state_d = ST_BOOT;
        end
      end
      ST_BOOT: begin
        state_d = ST_BOOT;
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_cnt_q  <= '0;
      state_q    <= ST_POR;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      pll_rst_q  <= 1'b1;
      long_ind_q <= 1'b0;
      wb_boot_q  <= 1'b0;
    end else begin
      sync1_q    <= btn_n;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      pll_rst_q  <= (state_d == ST_POR) || (state_d == ST_SRST);
      long_ind_q <= (state_d == ST_LONG);
      wb_boot_q  <= (state_d == ST_BOOT);
    end
  end

  assign pll_rst  = pll_rst_q;
  assign long_ind = long_ind_q;
  assign wb_boot  = wb_boot_q;
  assign wb_sel   = BOOT_IMG;

endmodule

// File: tb/tb_sysmgr_rst_ctrl.sv
// tb/tb_sysmgr_rst_ctrl.sv - self-checking bench for sysmgr_rst_ctrl
module tb_sysmgr_rst_ctrl;

  localparam int POR  = 16;
  localparam int DEB  = 4;
  localparam int RST  = 8;
  localparam int LONG = 64;
  localparam logic [1:0] IMG = 2'b01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_n = 1'b1;
  logic       pll_rst, long_ind, wb_boot;
  logic [1:0] wb_sel;

  int n_chk = 0;
  int n_pass = 0;
  bit wave[$];

  sysmgr_rst_ctrl #(
    .POR_CYCLES (POR),
    .DEB_CYCLES (DEB),
    .RST_CYCLES (RST),
    .LONG_CYCLES(LONG),
    .BOOT_IMG   (IMG)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .pll_rst (pll_rst),
    .long_ind(long_ind),
    .wb_boot (wb_boot),
    .wb_sel  (wb_sel)
  );

  always #5 clk = ~clk;

  // Reference: debounced level flips once the last DEB synchronised samples agree on a new value;
  // the sequencer is tracked as remaining-time budgets and flags.
  bit smp[0:DEB+1];
  bit m_deb, m_armed, m_long, m_boot, m_press, m_pll, m_stable, m_por_done;
  int m_por_left, m_rst_left, m_press_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DEB + 1; i++) smp[i] = 1'b1;
      m_deb = 1'b1; m_armed = 1'b0; m_long = 1'b0; m_boot = 1'b0; m_press = 1'b0;
      m_por_left = POR; m_rst_left = 0; m_press_len = 0;
    end else begin
      for (int i = DEB + 1; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = btn_n;
      m_stable = 1'b1;
      for (int i = 2; i <= DEB + 1; i++) if (smp[i] != smp[2]) m_stable = 1'b0;
      if (m_stable) m_deb = smp[2];
      m_por_done = (m_por_left == 0);
      if (!m_boot) begin
        if (m_long) begin
          if (m_deb) begin m_long = 1'b0; m_boot = 1'b1; end
        end else if (m_por_left > 0) begin
          m_por_left--;
        end else if (m_rst_left > 0) begin
          m_rst_left--;
        end else if (m_press) begin
          m_press_len++;
          if (m_press_len >= LONG) begin m_press = 1'b0; m_long = 1'b1; end
          else if (m_deb) begin m_press = 1'b0; m_rst_left = RST; end
        end else if (m_armed && !m_deb) begin
          m_press = 1'b1; m_press_len = 0;
        end
      end
      if (m_por_done && m_deb) m_armed = 1'b1;
    end
    m_pll = (m_por_left > 0) || (m_rst_left > 0);
  end

  task automatic test_reset();
    int hi;
    rst_n = 1'b0; btn_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({pll_rst, long_ind, wb_boot, wb_sel} !== {1'b1, 1'b0, 1'b0, IMG})
      $display("FAIL reset_values got %b want %b", {pll_rst, long_ind, wb_boot, wb_sel}, {1'b1, 1'b0, 1'b0, IMG});
    else n_pass++;
    rst_n = 1'b1;
    hi = (pll_rst === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pll_rst === 1'b1) hi++;
      n_chk++;
      if ({pll_rst, long_ind, wb_boot, wb_sel} !== {m_pll, m_long, m_boot, IMG})
        $display("FAIL por_model t=%0d got %b want %b", i, {pll_rst, long_ind, wb_boot, wb_sel}, {m_pll, m_long, m_boot, IMG});
      else n_pass++;
    end
    n_chk++;
    if (hi != POR) $display("FAIL por_width got %0d want %0d", hi, POR);
    else n_pass++;
  endtask

  task automatic test_short_press(input int reps);
    for (int r = 0; r < reps; r++) begin
      int idle, len, rel, first, hi;
      idle  = int'($urandom_range(5, 15));
      len   = int'($urandom_range(DEB + 1, 50));
      rel   = idle + len;
      first = -1;
      hi    = 0;
      for (int i = 0; i < rel + 30; i++) begin
        btn_n = (i >= idle && i < rel) ? 1'b0 : 1'b1;
        @(negedge clk);
        if (pll_rst === 1'b1) begin
          hi++;
          if (first < 0) first = i + 1;
        end
        n_chk++;
        if ({pll_rst, long_ind, wb_boot, wb_sel} !== {m_pll, m_long, m_boot, IMG})
          $display("FAIL short_model t=%0d got %b want %b", i, {pll_rst, long_ind, wb_boot, wb_sel}, {m_pll, m_long, m_boot, IMG});
        else n_pass++;
      end
      n_chk++;
      if (first - rel != DEB + 2) $display("FAIL short_start got %0d want %0d", first - rel, DEB + 2);
      else n_pass++;
      n_chk++;
      if (hi != RST) $display("FAIL short_width got %0d want %0d", hi, RST);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int per, hi;
    per = int'($urandom_range(1, DEB - 1));
    hi  = 0;
    for (int i = 0; i < 70; i++) begin
      btn_n = (i < 40) ? (((i / per) % 2) != 0) : 1'b1;
      @(negedge clk);
      if (pll_rst === 1'b1 || long_ind === 1'b1 || wb_boot === 1'b1) hi++;
      n_chk++;
      if ({pll_rst, long_ind, wb_boot, wb_sel} !== {m_pll, m_long, m_boot, IMG})
        $display("FAIL bounce_model t=%0d got %b want %b", i, {pll_rst, long_ind, wb_boot, wb_sel}, {m_pll, m_long, m_boot, IMG});
      else n_pass++;
    end
    n_chk++;
    if (hi != 0) $display("FAIL bounce_quiet got %0d active cycles want 0", hi);
    else n_pass++;
  endtask

  task automatic test_long_press();
    int len, rise_l, rise_b, boot_hi;
    len = int'($urandom_range(80, 120));
    rise_l = -1; rise_b = -1; boot_hi = 0;
    for (int i = 0; i < 5 + len + 1000; i++) begin
      btn_n = (i >= 5 && i < 5 + len) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (long_ind === 1'b1 && rise_l < 0) rise_l = i + 1;
      if (wb_boot === 1'b1) begin
        boot_hi++;
        if (rise_b < 0) rise_b = i + 1;
      end
      n_chk++;
      if ({pll_rst, long_ind, wb_boot, wb_sel} !== {m_pll, m_long, m_boot, IMG})
        $display("FAIL long_model t=%0d got %b want %b", i, {pll_rst, long_ind, wb_boot, wb_sel}, {m_pll, m_long, m_boot, IMG});
      else n_pass++;
    end
    n_chk++;
    if (rise_l - 5 != DEB + 2 + LONG) $display("FAIL long_ind_rise got %0d want %0d", rise_l - 5, DEB + 2 + LONG);
    else n_pass++;
    n_chk++;
    if (rise_b - (5 + len) != DEB + 2) $display("FAIL boot_rise got %0d want %0d", rise_b - (5 + len), DEB + 2);
    else n_pass++;
    n_chk++;
    if (boot_hi != 1000 - (DEB + 2) + 1) $display("FAIL boot_hold got %0d want %0d", boot_hi, 1000 - (DEB + 2) + 1);
    else n_pass++;
    n_chk++;
    if ({long_ind, wb_boot} !== 2'b01) $display("FAIL boot_final got %b want 01", {long_ind, wb_boot});
    else n_pass++;
  endtask

  task automatic test_held_power_up();
    int hi, hi2;
    rst_n = 1'b0; btn_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi = 0; hi2 = 0;
    for (int i = 0; i < POR + 200 + 40 + 20 + 30; i++) begin
      btn_n = (i < POR + 200) ? 1'b0 : (i >= POR + 240 && i < POR + 260) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (i + 1 > POR && i < POR + 240 && (pll_rst === 1'b1 || wb_boot === 1'b1 || long_ind === 1'b1)) hi++;
      if (i >= POR + 240 && pll_rst === 1'b1) hi2++;
      n_chk++;
      if ({pll_rst, long_ind, wb_boot, wb_sel} !== {m_pll, m_long, m_boot, IMG})
        $display("FAIL held_model t=%0d got %b want %b", i, {pll_rst, long_ind, wb_boot, wb_sel}, {m_pll, m_long, m_boot, IMG});
      else n_pass++;
    end
    n_chk++;
    if (hi != 0) $display("FAIL held_no_action got %0d active cycles want 0", hi);
    else n_pass++;
    n_chk++;
    if (hi2 != RST) $display("FAIL held_then_short got %0d want %0d", hi2, RST);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int hi;
    btn_n = 1'b0;
    repeat (20) @(negedge clk);
    btn_n = 1'b1;
    for (int k = 0; k < 50 && pll_rst !== 1'b1; k++) @(negedge clk);
    n_chk++;
    if (pll_rst !== 1'b1) $display("FAIL srst_reached got %b want 1", pll_rst);
    else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({pll_rst, long_ind, wb_boot} !== 3'b100) $display("FAIL srst_async got %b want 100", {pll_rst, long_ind, wb_boot});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    hi = (pll_rst === 1'b1) ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pll_rst === 1'b1) hi++;
    end
    n_chk++;
    if (hi != POR) $display("FAIL srst_por_width got %0d want %0d", hi, POR);
    else n_pass++;
    btn_n = 1'b0;
    repeat (LONG + 20) @(negedge clk);
    btn_n = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    n_chk++;
    if (wb_boot !== 1'b1) $display("FAIL boot_reached got %b want 1", wb_boot);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({pll_rst, long_ind, wb_boot} !== 3'b100) $display("FAIL boot_async got %b want 100", {pll_rst, long_ind, wb_boot});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    hi = (pll_rst === 1'b1) ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pll_rst === 1'b1) hi++;
    end
    n_chk++;
    if (hi != POR) $display("FAIL boot_por_width got %0d want %0d", hi, POR);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      rst_n = 1'b0; btn_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wave.delete();
      while (wave.size() < 800) begin
        int k, n, h;
        bit v;
        k = int'($urandom_range(0, 19));
        if (k < 8) begin
          n = int'($urandom_range(1, DEB - 1));
          v = 1'($urandom_range(0, 1));
          repeat (n) wave.push_back(v);
        end else if (k < 14) begin
          n = int'($urandom_range(DEB, 50));
          h = int'($urandom_range(5, 30));
          repeat (n) wave.push_back(1'b0);
          repeat (h) wave.push_back(1'b1);
        end else if (k == 19) begin
          n = int'($urandom_range(LONG - 4, LONG + 30));
          repeat (n) wave.push_back(1'b0);
          repeat (20) wave.push_back(1'b1);
        end else begin
          n = int'($urandom_range(5, 40));
          repeat (n) wave.push_back(1'b1);
        end
      end
      for (int i = 0; i < wave.size(); i++) begin
        btn_n = wave[i];
        @(negedge clk);
        n_chk++;
        if ({pll_rst, long_ind, wb_boot, wb_sel} !== {m_pll, m_long, m_boot, IMG})
          $display("FAIL random_model r=%0d t=%0d got %b want %b", r, i, {pll_rst, long_ind, wb_boot, wb_sel}, {m_pll, m_long, m_boot, IMG});
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press(3);
    test_bounce();
    test_long_press();
    test_held_power_up();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
